icache_ctrl: RTL and testbench
==============================

Name: icache_ctrl

Overview:
- Direct-mapped, one-word-per-line instruction cache controller between the IF stage and the byte-serial memory controller's instruction port.
- Hits return in one cycle. A miss sequences a single word refill through the `inst_needed`/`inst_available` handshake.
- Honours `branch_interception` by cancelling the in-flight fetch, and supports a whole-cache invalidate.

Parameters:
- INDEX_BITS, 7, number of index bits. The cache holds 2^INDEX_BITS 32-bit lines.
- ADDR_WIDTH, 32, instruction address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high (`RstEnable = 1)
- branch_interception  in  1  cancel current fetch (mispredict/redirect)
- invalidate  in  1  clear all valid bits (fence.i)
- if_req  in  1  IF fetch request; held with if_addr stable until if_valid or branch_interception
- if_addr  in  ADDR_WIDTH  fetch address; word aligned, bits [1:0] ignored
- if_valid  out  1  one-cycle pulse, if_inst valid
- if_inst  out  32  fetched instruction
- inst_needed  out  1  refill request to memory controller
- inst_addr_o  out  ADDR_WIDTH  refill address, bits [1:0] forced 0
- inst_in  in  32  refill data from memory controller
- inst_available  in  1  one-cycle pulse, inst_in valid

Behaviour:
- Address split:
  - index = if_addr[INDEX_BITS+1:2]
  - tag = if_addr[ADDR_WIDTH-1:INDEX_BITS+2]
  - Arrays: valid[2^INDEX_BITS], tag[], data[]. Arrays are read combinationally and written on posedge.
- Reset (async, rst=1):
  - all valid bits 0, state IDLE
  - if_valid=0, if_inst=0, inst_needed=0, inst_addr_o=0
  - tag/data arrays not reset
- States: IDLE, MISS.
- IDLE, cycle with if_req=1, if_valid=0, branch_interception=0:
  - hit (valid & tag match): next edge if_inst<=data[index], if_valid<=1; stay IDLE.
  - miss: next edge inst_needed<=1, inst_addr_o<={if_addr[31:2],2'b00}; go to MISS.
- IDLE never samples if_req in a cycle where if_valid=1. This prevents duplicate issue of a held address. Throughput is one instruction per 2 cycles on hits.
- IDLE with branch_interception=1: no response, no refill, state unchanged.
- MISS:
  - hold inst_needed=1 and inst_addr_o stable until inst_available=1.
  - On the inst_available edge:
    - data/tag written, valid set
    - if_inst<=inst_in, if_valid<=1
    - inst_needed<=0
    - go to IDLE
  - The refill word is not bypassed. Total miss latency = (cycles to inst_available) + 1.
- branch_interception in MISS, inst_available=0: next edge inst_needed<=0, go to IDLE, no fill, no if_valid. The memory controller drops its busy fetch on the same signal.
- branch_interception and inst_available in the same cycle: line is filled and marked valid, but if_valid stays 0; go to IDLE.
- if_valid is forced 0 in any cycle following a cycle with branch_interception=1.
- invalidate=1:
  - next edge clears all valid bits, in any state.
  - If coincident with a refill write, invalidate wins: the line is written but valid stays 0. The refill still produces if_valid (the word is correct for this fetch).
  - A hit lookup in the same cycle as invalidate still returns data.
- if_inst holds its last value when if_valid=0.
- inst_needed is never asserted outside MISS. inst_addr_o changes only on entry to MISS.

Test Plan:
- Reset: assert rst mid-MISS with inst_needed=1 -> inst_needed, if_valid drop to 0 immediately (async); the next request to the same address misses.
- Cold miss then hit: if_req addr 0x0000_0004 -> inst_needed=1, inst_addr_o=0x4; return inst_in=0x00A00093 with inst_available at cycle k -> if_valid=1, if_inst=0x00A00093 at k+1. Re-request 0x4 -> if_valid one cycle after sampling, inst_needed stays 0.
- Conflict eviction: after filling 0x4, request 0x0000_0204 (same index 1, different tag) -> miss, refill 0x12345678. Then 0x4 misses again.
- Branch during miss: miss on 0x8, assert branch_interception 3 cycles later -> inst_needed=0 next edge, no if_valid. A late inst_available is ignored (state IDLE). Re-request 0x8 misses.
- Simultaneous branch + inst_available on a refill of 0xC -> no if_valid. A later request of 0xC hits with the refilled data.
- Invalidate: fill 0x4 and 0x10, pulse invalidate -> both subsequent requests miss. Invalidate coincident with refill of 0x14 -> if_valid=1 with data, but the next 0x14 request misses.

Source files
------------

// File: rtl/icache_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : icache_ctrl_if
//  Description : Fetch-side and refill-side handshake bundle for icache_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
interface icache_ctrl_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  branch_interception;
    logic                  invalidate;
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_valid;
    logic [31:0]           if_inst;
    logic                  inst_needed;
    logic [ADDR_WIDTH-1:0] inst_addr_o;
    logic [31:0]           inst_in;
    logic                  inst_available;

    // master: IF stage plus memory controller; slave: the cache controller
    modport master (
        output branch_interception, invalidate, if_req, if_addr,
        output inst_in, inst_available,
        input  if_valid, if_inst, inst_needed, inst_addr_o
    );

    modport slave (
        input  branch_interception, invalidate, if_req, if_addr,
        input  inst_in, inst_available,
        output if_valid, if_inst, inst_needed, inst_addr_o
    );
endinterface
`default_nettype wire

// File: rtl/icache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : icache_ctrl
//  Description : Direct-mapped, one-word-per-line instruction cache controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_ctrl #(
    parameter int INDEX_BITS = 7,
    parameter int ADDR_WIDTH = 32
) (
    input  wire logic     clk,
    input  wire logic     rst,
    icache_ctrl_if.slave  bus
);

    localparam int c_DEPTH    = 1 << INDEX_BITS;
    localparam int c_TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_MISS = 1'b1;

    logic [0:0]            r_state;
    logic [c_DEPTH-1:0]    r_valid;
    logic [c_TAG_BITS-1:0] r_tag_mem  [c_DEPTH];
    logic [31:0]           r_data_mem [c_DEPTH];

    logic                  r_if_valid;
    logic [31:0]           r_if_inst;
    logic                  r_inst_needed;
    logic [ADDR_WIDTH-1:0] r_inst_addr;

    logic [INDEX_BITS-1:0] w_index;
    logic [c_TAG_BITS-1:0] w_tag;
    logic [INDEX_BITS-1:0] w_fill_index;
    logic [c_TAG_BITS-1:0] w_fill_tag;
    logic                  w_hit;
    logic                  w_lookup;
    logic                  w_fill;
    wire                   w_unused_addr_lsbs = ^bus.if_addr[1:0];

    assign w_index      = bus.if_addr[INDEX_BITS+1:2];
    assign w_tag        = bus.if_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign w_fill_index = r_inst_addr[INDEX_BITS+1:2];
    assign w_fill_tag   = r_inst_addr[ADDR_WIDTH-1:INDEX_BITS+2];

    assign w_hit    = r_valid[w_index] && (r_tag_mem[w_index] == w_tag);
    // A held request is not re-sampled while its response is on the bus
    assign w_lookup = (r_state == c_ST_IDLE) && bus.if_req && !r_if_valid &&
                      !bus.branch_interception;
    assign w_fill   = (r_state == c_ST_MISS) && bus.inst_available;

    assign bus.if_valid    = r_if_valid;
    assign bus.if_inst     = r_if_inst;
    assign bus.inst_needed = r_inst_needed;
    assign bus.inst_addr_o = r_inst_addr;

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag_mem[w_fill_index]  <= w_fill_tag;
            r_data_mem[w_fill_index] <= bus.inst_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_valid       <= '0;
            r_if_valid    <= 1'b0;
            r_if_inst     <= 32'h0;
            r_inst_needed <= 1'b0;
            r_inst_addr   <= '0;
        end else begin
            r_if_valid <= 1'b0;

            // Invalidate overrides a coincident refill's valid bit
            if (bus.invalidate) begin
                r_valid <= '0;
            end else if (w_fill) begin
                r_valid[w_fill_index] <= 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_lookup) begin
                        if (w_hit) begin
                            r_if_inst  <= r_data_mem[w_index];
                            r_if_valid <= 1'b1;
                        end else begin
                            r_inst_needed <= 1'b1;
                            r_inst_addr   <= {bus.if_addr[ADDR_WIDTH-1:2], 2'b00};
                            r_state       <= c_ST_MISS;
                        end
                    end
                end
                c_ST_MISS: begin
                    if (bus.inst_available) begin
                        if (!bus.branch_interception) begin
                            r_if_inst  <= bus.inst_in;
                            r_if_valid <= 1'b1;
                        end
                        r_inst_needed <= 1'b0;
                        r_state       <= c_ST_IDLE;
                    end else if (bus.branch_interception) begin
                        r_inst_needed <= 1'b0;
                        r_state       <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_inst_needed <= 1'b0;
                    r_state       <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_ctrl
//  Description : Directed and random fetch sequences against a cache model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_ctrl;

    localparam int c_INDEX_BITS = 7;
    localparam int c_DEPTH      = 1 << c_INDEX_BITS;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    icache_ctrl_if #(.ADDR_WIDTH(32)) bus ();

    icache_ctrl #(
        .INDEX_BITS (c_INDEX_BITS),
        .ADDR_WIDTH (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cache: one entry per index
    bit          m_valid [c_DEPTH];
    logic [22:0] m_tag   [c_DEPTH];
    logic [31:0] m_data  [c_DEPTH];
    logic [31:0] last_inst;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < c_DEPTH; i++) m_valid[i] = 1'b0;
    endtask

    // mode: 0 plain, 1 invalidate with fill, 2 branch with fill,
    //       3 branch while waiting (late data ignored), 4 invalidate with lookup
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                         input int delay, input int mode);
        int          idx;
        logic [22:0] tg;
        bit          hit;
        idx = int'(addr[8:2]);
        tg  = addr[31:9];
        hit = m_valid[idx] && (m_tag[idx] == tg);

        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        if (mode == 4) bus.invalidate = 1'b1;
        tick();
        bus.invalidate = 1'b0;
        if (mode == 4) model_clear();

        if (hit) begin
            check("hit_valid", {31'b0, bus.if_valid}, 32'd1);
            check("hit_inst", bus.if_inst, m_data[idx]);
            check("hit_no_refill", {31'b0, bus.inst_needed}, 32'd0);
            last_inst = m_data[idx];
            tick();
            check("no_dup_valid", {31'b0, bus.if_valid}, 32'd0);
            check("no_dup_refill", {31'b0, bus.inst_needed}, 32'd0);
            bus.if_req = 1'b0;
            return;
        end

        check("miss_needed", {31'b0, bus.inst_needed}, 32'd1);
        check("miss_addr", bus.inst_addr_o, {addr[31:2], 2'b00});
        check("miss_no_valid", {31'b0, bus.if_valid}, 32'd0);
        repeat (delay) tick();
        check("miss_hold", {31'b0, bus.inst_needed}, 32'd1);
        check("miss_addr_hold", bus.inst_addr_o, {addr[31:2], 2'b00});

        if (mode == 3) begin
            bus.branch_interception = 1'b1;
            tick();
            bus.branch_interception = 1'b0;
            bus.if_req = 1'b0;
            check("br_drop_needed", {31'b0, bus.inst_needed}, 32'd0);
            check("br_no_valid", {31'b0, bus.if_valid}, 32'd0);
            bus.inst_in = data;
            bus.inst_available = 1'b1;
            tick();
            bus.inst_available = 1'b0;
            check("late_avail_ignored", {31'b0, bus.if_valid}, 32'd0);
            check("late_avail_needed", {31'b0, bus.inst_needed}, 32'd0);
            check("br_inst_hold", bus.if_inst, last_inst);
            return;
        end

        bus.inst_in = data;
        bus.inst_available = 1'b1;
        if (mode == 1) bus.invalidate = 1'b1;
        if (mode == 2) bus.branch_interception = 1'b1;
        tick();
        bus.inst_available = 1'b0;
        bus.invalidate = 1'b0;
        bus.branch_interception = 1'b0;
        if (mode == 2) bus.if_req = 1'b0;

        m_tag[idx]  = tg;
        m_data[idx] = data;
        m_valid[idx] = 1'b1;
        if (mode == 1) model_clear();

        if (mode == 2) begin
            check("brfill_no_valid", {31'b0, bus.if_valid}, 32'd0);
        end else begin
            check("fill_valid", {31'b0, bus.if_valid}, 32'd1);
            check("fill_inst", bus.if_inst, data);
            last_inst = data;
        end
        check("fill_needed_low", {31'b0, bus.inst_needed}, 32'd0);
        tick();
        bus.if_req = 1'b0;
        check("fill_pulse", {31'b0, bus.if_valid}, 32'd0);
        check("fill_no_reissue", {31'b0, bus.inst_needed}, 32'd0);
        check("inst_hold", bus.if_inst, last_inst);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        last_inst = 32'h0;
        model_clear();
        rst = 1'b1;
        bus.branch_interception = 1'b0;
        bus.invalidate = 1'b0;
        bus.if_req = 1'b0;
        bus.if_addr = 32'h0;
        bus.inst_in = 32'h0;
        bus.inst_available = 1'b0;
        repeat (3) tick();
        check("rst_if_valid", {31'b0, bus.if_valid}, 32'd0);
        check("rst_if_inst", bus.if_inst, 32'h0);
        check("rst_needed", {31'b0, bus.inst_needed}, 32'd0);
        check("rst_addr", bus.inst_addr_o, 32'h0);
        rst = 1'b0;
        tick();

        // Cold miss then hit
        fetch(32'h0000_0004, 32'h00A0_0093, 3, 0);
        fetch(32'h0000_0004, 32'h00A0_0093, 0, 0);

        // Conflict eviction on index 1
        fetch(32'h0000_0204, 32'h1234_5678, 2, 0);
        fetch(32'h0000_0204, 32'h1234_5678, 0, 0);
        fetch(32'h0000_0004, 32'h00A0_0093, 1, 0);

        // Branch during miss, then re-request misses
        fetch(32'h0000_0008, 32'hDEAD_0008, 2, 3);
        fetch(32'h0000_0008, 32'h0000_8888, 0, 0);

        // Branch coincident with refill: line filled, no response
        fetch(32'h0000_000C, 32'hCAFE_000C, 1, 2);
        fetch(32'h0000_000C, 32'h0, 0, 0);

        // Whole-cache invalidate
        fetch(32'h0000_0010, 32'h0101_0010, 0, 0);
        bus.invalidate = 1'b1;
        tick();
        bus.invalidate = 1'b0;
        model_clear();
        fetch(32'h0000_0004, 32'h00A0_0093, 1, 0);
        fetch(32'h0000_0010, 32'h0101_0010, 0, 0);

        // Invalidate coincident with refill, then lookup-cycle invalidate on a hit
        fetch(32'h0000_0014, 32'h1414_1414, 2, 1);
        fetch(32'h0000_0014, 32'h1414_1414, 0, 0);
        fetch(32'h0000_0014, 32'h1414_1414, 0, 4);
        fetch(32'h0000_0014, 32'h1414_0000, 0, 0);

        // Asynchronous reset in the middle of a miss
        bus.if_req = 1'b1;
        bus.if_addr = 32'h0000_0040;
        tick();
        check("pre_rst_needed", {31'b0, bus.inst_needed}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_needed", {31'b0, bus.inst_needed}, 32'd0);
        check("async_rst_valid", {31'b0, bus.if_valid}, 32'd0);
        bus.if_req = 1'b0;
        tick();
        rst = 1'b0;
        model_clear();
        last_inst = 32'h0;
        tick();
        fetch(32'h0000_0040, 32'h4040_4040, 1, 0);

        // Random traffic over a small address pool to mix hits and conflicts
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            int          m;
            int          r;
            a = {21'h0, 2'($urandom_range(0, 3)), 2'b00, 3'($urandom_range(0, 7)), 2'b00, 2'($urandom)};
            r = int'($urandom_range(0, 9));
            m = (r < 6) ? 0 : (r - 5);
            fetch(a, $urandom, int'($urandom_range(0, 4)), m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
